// File: rtl/axi_lite_reg_bank_if.sv
// AXI4-Lite bus bundle between one PS master port and the register bank.
interface axi_lite_reg_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                      awvalid;
    logic                      awready;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic                      wvalid;
    logic                      wready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      bvalid;
    logic                      bready;
    logic [1:0]                bresp;
    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite target register bank: NUM_REGS software (RW) or fabric-status (RO)
// registers, byte strobes, SLVERR on out-of-range or RO writes, access pulses.
//
// state  | meaning
// W_IDLE | collecting AW and W beats (either order, either may be held)
// W_RESP | write committed, bvalid high until bready
// R_IDLE | arready high, waiting for AR
// R_RESP | rdata/rresp held with rvalid high until rready
module axi_lite_reg_bank #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    axi_lite_reg_bank_if.slave             axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_in,
    output logic [NUM_REGS-1:0]            write_pulse,
    output logic [NUM_REGS-1:0]            read_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int B      = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t r_wstate, w_wstate_next;
    rstate_t r_rstate, w_rstate_next;

    // Keeps readies low during reset and lets them rise once reset is released.
    logic                   r_active;
    logic                   r_aw_held;
    logic [ADDR_WIDTH-1:0]  r_aw_addr;
    logic                   r_w_held;
    logic [DATA_WIDTH-1:0]  r_w_data;
    logic [STRB_W-1:0]      r_w_strb;
    logic [1:0]             r_bresp;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]             r_rresp;
    logic [NUM_REGS-1:0]    r_write_pulse;
    logic [NUM_REGS-1:0]    r_read_pulse;
    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

    logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0]  w_aw_addr, w_aw_idx_full, w_ar_idx_full;
    logic [DATA_WIDTH-1:0]  w_w_data;
    logic [STRB_W-1:0]      w_w_strb;
    logic [IDX_W-1:0]       w_widx, w_ridx;
    logic                   w_w_in_range, w_r_in_range, w_w_ok;

    assign axi.awready = r_active && (r_wstate == W_IDLE) && !r_aw_held;
    assign axi.wready  = r_active && (r_wstate == W_IDLE) && !r_w_held;
    assign axi.arready = r_active && (r_rstate == R_IDLE);
    assign axi.bvalid  = (r_wstate == W_RESP);
    assign axi.rvalid  = (r_rstate == R_RESP);
    assign axi.bresp   = r_bresp;
    assign axi.rdata   = r_rdata;
    assign axi.rresp   = r_rresp;
    assign write_pulse = r_write_pulse;
    assign read_pulse  = r_read_pulse;

    assign w_aw_hs = axi.awvalid && axi.awready;
    assign w_w_hs  = axi.wvalid && axi.wready;
    assign w_ar_hs = axi.arvalid && axi.arready;

    // A held beat takes priority; otherwise the beat arriving this cycle is used.
    assign w_aw_addr = r_aw_held ? r_aw_addr : axi.awaddr;
    assign w_w_data  = r_w_held  ? r_w_data  : axi.wdata;
    assign w_w_strb  = r_w_held  ? r_w_strb  : axi.wstrb;
    assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_aw_idx_full = w_aw_addr >> B;
    assign w_ar_idx_full = axi.araddr >> B;
    assign w_widx        = w_aw_idx_full[IDX_W-1:0];
    assign w_ridx        = w_ar_idx_full[IDX_W-1:0];
    assign w_w_in_range  = w_aw_idx_full < NUM_REGS_A;
    assign w_r_in_range  = w_ar_idx_full < NUM_REGS_A;
    assign w_w_ok        = w_w_in_range && !RO_MASK[w_widx];

    // RO slots expose 0; their live value comes from regs_in on reads.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : r_regs[i];
    end

    // State registers for both channel FSMs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_active <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
            r_active <= 1'b1;
        end
    end

    // Next-state logic for the write and read channels.
    always_comb begin
        w_wstate_next = r_wstate;
        w_rstate_next = r_rstate;
        case (r_wstate)
            W_IDLE: if (w_commit)   w_wstate_next = W_RESP;
            W_RESP: if (axi.bready) w_wstate_next = W_IDLE;
        endcase
        case (r_rstate)
            R_IDLE: if (w_ar_hs)    w_rstate_next = R_RESP;
            R_RESP: if (axi.rready) w_rstate_next = R_IDLE;
        endcase
    end

    // Beat capture, strobed register commit and write response.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_aw_held     <= 1'b0;
            r_aw_addr     <= '0;
            r_w_held      <= 1'b0;
            r_w_data      <= '0;
            r_w_strb      <= '0;
            r_bresp       <= RESP_OKAY;
            r_write_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
        end else begin
            r_write_pulse <= '0;
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_w_ok ? RESP_OKAY : RESP_SLVERR;
                if (w_w_ok) begin
                    r_write_pulse <= NUM_REGS'(1) << w_widx;
                    for (int b = 0; b < STRB_W; b++)
                        if (w_w_strb[b])
                            r_regs[w_widx][8*b +: 8] <= w_w_data[8*b +: 8];
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= axi.awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_w_data <= axi.wdata;
                    r_w_strb <= axi.wstrb;
                end
            end
        end
    end

    // Read sampling; same-edge writes are not yet visible, so reads see the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata      <= '0;
            r_rresp      <= RESP_OKAY;
            r_read_pulse <= '0;
        end else begin
            r_read_pulse <= '0;
            if (w_ar_hs) begin
                if (w_r_in_range) begin
                    r_rdata      <= RO_MASK[w_ridx] ? regs_in[w_ridx*DATA_WIDTH +: DATA_WIDTH]
                                                    : r_regs[w_ridx];
                    r_rresp      <= RESP_OKAY;
                    r_read_pulse <= NUM_REGS'(1) << w_ridx;
                end else begin
                    r_rdata <= '0;
                    r_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    a_bvalid_hold: assert property (@(posedge clock) disable iff (reset)
        (axi.bvalid && !axi.bready) |=> (axi.bvalid && $stable(axi.bresp)));
    a_rvalid_hold: assert property (@(posedge clock) disable iff (reset)
        (axi.rvalid && !axi.rready) |=> (axi.rvalid && $stable(axi.rdata) && $stable(axi.rresp)));
endmodule

// File: doc/axi_lite_reg_bank.md
Name: axi_lite_reg_bank

Overview:
Parametrised AXI4-Lite target register bank. It is the successor to the fixed 32-bit PS-GP-to-ZynqGameboy control path. It terminates one PS master port and exposes NUM_REGS registers to fabric logic. Each register is either read/write (software controlled) or read-only (fabric status). The bank supports byte strobes, configurable data width, out-of-range error responses, and per-register access pulses.

Parameters:
- DATA_WIDTH, 32: AXI data and register width; legal values are 32 and 64.
- ADDR_WIDTH, 32: AXI address width.
- NUM_REGS, 8: number of registers, 1..256.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes register i read-only.
- RESET_VALUE, 0: DATA_WIDTH-bit reset value for every read/write register.

Ports:
- clock  in  1  Single clock. All logic is rising-edge.
- reset  in  1  Synchronous, active-high.
- axi_awvalid/awready  in/out  1  Write address handshake.
- axi_awaddr  in  ADDR_WIDTH  Write byte address.
- axi_wvalid/wready  in/out  1  Write data handshake.
- axi_wdata  in  DATA_WIDTH  Write data.
- axi_wstrb  in  DATA_WIDTH/8  Byte enables.
- axi_bvalid/bready  out/in  1  Write response handshake.
- axi_bresp  out  2  Write response: OKAY=00, SLVERR=10.
- axi_arvalid/arready  in/out  1  Read address handshake.
- axi_araddr  in  ADDR_WIDTH  Read byte address.
- axi_rvalid/rready  out/in  1  Read data handshake.
- axi_rdata  out  DATA_WIDTH  Read data.
- axi_rresp  out  2  Read response.
- regs_out  out  NUM_REGS*DATA_WIDTH  Current read/write register values; register i occupies slice i.
- regs_in  in  NUM_REGS*DATA_WIDTH  Status values returned for read-only registers.
- write_pulse  out  NUM_REGS  One-cycle strobe per committed write.
- read_pulse  out  NUM_REGS  One-cycle strobe per completed read.

Behaviour:
- Address decode:
  - B = log2(DATA_WIDTH/8).
  - Register index = awaddr or araddr >> B. The low B bits are ignored.
  - An access is in range when index < NUM_REGS.
- Reset values:
  - awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, write_pulse and read_pulse are all 0.
  - Read/write registers take RESET_VALUE.
  - The ready signals rise in the first cycle after reset deasserts.
- Write FSM (states W_IDLE, W_RESP):
  - In W_IDLE, AW and W are accepted independently and in either order.
  - Each ready drops once its beat is captured and stays low until the response completes.
  - The write commits on the edge that ends the cycle N in which the second of AW/W is captured. Captured AW/W may be mixed with the same-cycle beat.
  - From cycle N+1: state is W_RESP, bvalid=1, and write_pulse[index]=1 for exactly one cycle.
  - Only bytes with wstrb=1 are updated.
  - bvalid, bresp and the FSM state hold until bready; on the bready cycle the FSM returns to W_IDLE.
  - awready and wready reassert the cycle after the bready handshake.
- Write errors:
  - Out of range: no register changes, no pulse, bresp=SLVERR.
  - Read-only target: data discarded, no pulse, bresp=SLVERR.
  - In-range read/write target: bresp=OKAY.
- Read FSM (states R_IDLE, R_RESP):
  - In R_IDLE, arready=1.
  - An AR handshake in cycle N gives rvalid=1 and read_pulse[index]=1 (one cycle) from cycle N+1.
  - rdata is sampled at the edge ending cycle N:
    - read/write register: its register value;
    - read-only register: the regs_in slice;
    - out of range: rdata=0 and rresp=SLVERR.
  - rdata and rresp are held stable until rready.
  - arready=0 while rvalid=1; it reasserts the cycle after the rready handshake.
- Read and write channels are fully independent and may be active in the same cycle.
- If a read samples in the same cycle a write commits to the same register, the read returns the pre-write value.
- At most one outstanding transaction per channel. There is no buffering beyond one captured AW and one captured W.
- Reset mid-transaction aborts everything:
  - captured beats are dropped;
  - no commit occurs;
  - bvalid and rvalid clear.
- Registers in RO_MASK drive 0 on their regs_out slice.
- Assertion: ready/valid handshakes never drop valid before the handshake completes (protocol check on the outputs).

Test Plan:
1. Reset, then write AW=0x04 with W=0xDEADBEEF, wstrb=0xF (DATA_WIDTH=32) in the same cycle N.
   - Required: bvalid=1 and bresp=00 from cycle N+1.
   - Required: regs_out slice 1 = 0xDEADBEEF.
   - Required: write_pulse=0x02 for one cycle.
2. W beat 0x11223344 three cycles before AW=0x08, with wstrb=0x5.
   - Required: awready stays 1 until AW arrives, and the commit occurs only after AW.
   - Required: register 2 = 0x00220044 when RESET_VALUE=0.
3. Write to 0x40 with NUM_REGS=8, then read 0x40.
   - Required: bresp=10 with all registers unchanged.
   - Required: rresp=10, rdata=0, and no pulses.
4. RO_MASK=0x01 with regs_in slice 0=0xCAFE0001: read 0x00, then write 0x00 with 0xFFFFFFFF.
   - Required: rdata=0xCAFE0001, rresp=00.
   - Required: write returns bresp=10, no write_pulse, and regs_out slice 0 stays 0.
5. Hold bready=0 and rready=0 for 5 cycles after valid.
   - Required: bvalid, rvalid, rdata and resp are stable; awready, wready and arready are 0.
   - Required: readies reassert 1 cycle after the handshakes.
6. DATA_WIDTH=64: write 0x08 with wstrb=0xF0, simultaneously read 0x08 at the commit edge, then assert reset while a second W is captured without AW.
   - Required: the simultaneous read returns the old value.
   - Required: register 1 upper 32 bits are updated.
   - Required: after reset, register 1 = RESET_VALUE and there is no pending write.
